// File: rtl/hsid_pkg.sv
// Shared HSID types and constants: word widths, read-arbiter FSM states and limits.
package hsid_pkg;

   localparam int unsigned HSID_WORD_WIDTH        = 32;
   localparam int unsigned HSID_HSP_LIBRARY_WIDTH = 16;
   localparam int unsigned HSID_X_ARB_TIMEOUT     = 1024;
   localparam int unsigned HSID_X_ARB_MAX_REQ     = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_START,
      ARB_BUSY,
      ARB_DONE
   } hsid_x_arb_state_t;

endpackage

// File: rtl/hsid_x_rr_picker.sv
// Combinational round-robin selector: first set request at or above rr_ptr, with wrap.
module hsid_x_rr_picker #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // rr_ptr < NUM_REQ, so one conditional subtract is enough to wrap.
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         idx = sum[IDX_W-1:0];
         if (!any_req && req[idx]) begin
            any_req    = 1'b1;
            grant_idx  = idx;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hsid_x_obi_read_arbiter.sv
// Round-robin arbiter sharing one OBI read engine between NUM_REQ fetch requesters.
// Optional watchdog abort of stalled jobs: define HSID_X_ARB_WATCHDOG_EN.
module hsid_x_obi_read_arbiter
   import hsid_pkg::*;
#(
   parameter int unsigned NUM_REQ           = 2,
   parameter int unsigned WORD_WIDTH        = HSID_WORD_WIDTH,
   parameter int unsigned HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES    = HSID_X_ARB_TIMEOUT
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*WORD_WIDTH-1:0]        req_addr,
   input  logic [NUM_REQ*HSP_LIBRARY_WIDTH-1:0] req_limit,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic [NUM_REQ-1:0]                   req_done,
   output logic [WORD_WIDTH-1:0]                obi_initial_addr,
   output logic [HSP_LIBRARY_WIDTH-1:0]         obi_limit_in,
   output logic                                 obi_start,
   input  logic                                 obi_done,
   output logic                                 busy,
   output logic [$clog2(NUM_REQ)-1:0]           grant_id,
   output logic                                 error
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > HSID_X_ARB_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("hsid_x_obi_read_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   hsid_x_arb_state_t             state;
   logic [IDX_W-1:0]              rr_ptr;
   logic [NUM_REQ-1:0]            pick_grant;
   logic [IDX_W-1:0]              pick_idx;
   logic                          any_req;
   logic [WORD_WIDTH-1:0]         win_addr;
   logic [HSP_LIBRARY_WIDTH-1:0]  win_limit;
   logic [NUM_REQ-1:0]            owner_onehot;

`ifdef HSID_X_ARB_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
`endif

   hsid_x_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any_req   (any_req)
   );

   always_comb begin
      win_addr  = '0;
      win_limit = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_grant[i]) begin
            win_addr  = req_addr[i*WORD_WIDTH +: WORD_WIDTH];
            win_limit = req_limit[i*HSP_LIBRARY_WIDTH +: HSP_LIBRARY_WIDTH];
         end
      end
   end

   assign req_ready    = (state == ARB_IDLE && !rst) ? pick_grant : '0;
   assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ARB_IDLE;
         rr_ptr           <= '0;
         busy             <= 1'b0;
         grant_id         <= '0;
         obi_initial_addr <= '0;
         obi_limit_in     <= '0;
         obi_start        <= 1'b0;
         req_done         <= '0;
         error            <= 1'b0;
`ifdef HSID_X_ARB_WATCHDOG_EN
         wd_cnt           <= '0;
`endif
      end else begin
         obi_start <= 1'b0;
         req_done  <= '0;
         // A done outside ARB_BUSY (including the start cycle) is dropped and only flagged.
         error     <= obi_done && (state != ARB_BUSY);
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  obi_initial_addr <= win_addr;
                  obi_limit_in     <= win_limit;
                  grant_id         <= pick_idx;
                  busy             <= 1'b1;
                  if (win_limit != '0) begin
                     state     <= ARB_START;
                     obi_start <= 1'b1;
                  end else begin
                     state    <= ARB_DONE;
                     req_done <= pick_grant;
                  end
               end
            end
            ARB_START: begin
               state <= ARB_BUSY;
`ifdef HSID_X_ARB_WATCHDOG_EN
               wd_cnt <= '0;
`endif
            end
            ARB_BUSY: begin
               if (obi_done) begin
                  state    <= ARB_DONE;
                  req_done <= owner_onehot;
               end
`ifdef HSID_X_ARB_WATCHDOG_EN
               else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  state    <= ARB_DONE;
                  req_done <= owner_onehot;
                  error    <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            ARB_DONE: begin
               state  <= ARB_IDLE;
               busy   <= 1'b0;
               rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hsid_x_obi_read_arbiter.sv
// Directed self-checking bench for hsid_x_obi_read_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
module tb_hsid_x_obi_read_arbiter;

   localparam int unsigned NR = 2;
   localparam int unsigned WW = 32;
   localparam int unsigned LW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*WW-1:0]  req_addr;
   logic [NR*LW-1:0]  req_limit;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_done;
   logic [WW-1:0]     obi_initial_addr;
   logic [LW-1:0]     obi_limit_in;
   logic              obi_start;
   logic              obi_done;
   logic              busy;
   logic [0:0]        grant_id;
   logic              error;

   int n_checks = 0;
   int n_fail   = 0;
   int start_cnt = 0;
   int done_cnt  = 0;
   int s0;
   int d0;

   hsid_x_obi_read_arbiter #(
      .NUM_REQ           (NR),
      .WORD_WIDTH        (WW),
      .HSP_LIBRARY_WIDTH (LW),
      .TIMEOUT_CYCLES    (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_addr         (req_addr),
      .req_limit        (req_limit),
      .req_ready        (req_ready),
      .req_done         (req_done),
      .obi_initial_addr (obi_initial_addr),
      .obi_limit_in     (obi_limit_in),
      .obi_start        (obi_start),
      .obi_done         (obi_done),
      .busy             (busy),
      .grant_id         (grant_id),
      .error            (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (obi_start) start_cnt++;
      if (req_done != '0) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [WW-1:0] a, input logic [LW-1:0] l);
      req_addr[id*WW +: WW]  = a;
      req_limit[id*LW +: LW] = l;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; req_limit = '0; obi_done = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_start", obi_start, 0);
      check("rst_done", req_done, 0);
      check("rst_error", error, 0);
      check("rst_gid", grant_id, 0);
      check("rst_addr", obi_initial_addr, 0);
      check("rst_ready", req_ready, 0);
      rst = 1'b0;

      // Single job on requester 0, engine done 10 cycles after start
      set_req(0, 32'h1000, 16'd8);
      req_valid = 2'b01;
      #1 check("t1_ready", req_ready, 2'b01);
      tick();
      check("t1_start", obi_start, 1);
      check("t1_addr", obi_initial_addr, 32'h1000);
      check("t1_limit", obi_limit_in, 8);
      check("t1_gid", grant_id, 0);
      check("t1_busy", busy, 1);
      check("t1_ready_low", req_ready, 0);
      req_valid = 2'b00;
      tick();
      check("t1_start_pulse", obi_start, 0);
      repeat (9) tick();
      obi_done = 1'b1;
      #1 check("t1_no_early_done", req_done, 0);
      tick();
      obi_done = 1'b0;
      check("t1_req_done", req_done, 2'b01);
      check("t1_no_err", error, 0);
      tick();
      check("t1_idle_busy", busy, 0);
      check("t1_done_pulse", req_done, 0);
      check("t1_start_cnt", start_cnt, 1);

      // Both requesters held valid: strict alternation 0,1,0,1
      reset_dut();
      set_req(0, 32'h2000, 16'd4);
      set_req(1, 32'h3000, 16'd5);
      req_valid = 2'b11;
      s0 = start_cnt;
      for (int j = 0; j < 4; j++) begin
         automatic logic [0:0] exp = 1'(j % 2);
         #1 check("t2_ready", req_ready, exp ? 2'b10 : 2'b01);
         tick();
         check("t2_gid", grant_id, exp);
         check("t2_start", obi_start, 1);
         check("t2_addr", obi_initial_addr, exp ? 32'h3000 : 32'h2000);
         tick();
         obi_done = 1'b1;
         tick();
         obi_done = 1'b0;
         check("t2_done", req_done, exp ? 2'b10 : 2'b01);
         tick();
      end
      req_valid = 2'b00;
      check("t2_start_cnt", start_cnt - s0, 4);

      // Zero-length job on requester 1
      set_req(1, 32'h4000, 16'd0);
      req_valid = 2'b10;
      #1 check("t3_ready", req_ready, 2'b10);
      s0 = start_cnt;
      tick();
      check("t3_done", req_done, 2'b10);
      check("t3_no_start", obi_start, 0);
      check("t3_no_err", error, 0);
      check("t3_gid", grant_id, 1);
      check("t3_busy", busy, 1);
      check("t3_limit", obi_limit_in, 0);
      req_valid = 2'b00;
      tick();
      check("t3_done_pulse", req_done, 0);
      check("t3_idle", busy, 0);
      check("t3_start_cnt", start_cnt - s0, 0);

      // Spurious done in idle, then done coinciding with the start cycle
      obi_done = 1'b1;
      tick();
      obi_done = 1'b0;
      check("t4_idle_err", error, 1);
      check("t4_idle_busy", busy, 0);
      check("t4_idle_done", req_done, 0);
      tick();
      check("t4_err_pulse", error, 0);
      set_req(0, 32'h5000, 16'd3);
      req_valid = 2'b01;
      tick();
      check("t4_start", obi_start, 1);
      req_valid = 2'b00;
      obi_done = 1'b1;
      tick();
      obi_done = 1'b0;
      check("t4_start_err", error, 1);
      check("t4_start_nodone", req_done, 0);
      check("t4_start_busy", busy, 1);
      tick();
      check("t4_busy_noerr", error, 0);
      check("t4_busy_nodone", req_done, 0);
      obi_done = 1'b1;
      tick();
      obi_done = 1'b0;
      check("t4_done", req_done, 2'b01);
      check("t4_done_noerr", error, 0);
      tick();

`ifdef HSID_X_ARB_WATCHDOG_EN
      // Engine never completes: abort after 16 busy cycles, then serve requester 1
      reset_dut();
      set_req(0, 32'h6000, 16'd7);
      req_valid = 2'b01;
      tick();
      set_req(1, 32'h7000, 16'd2);
      req_valid = 2'b10;
      tick();
      repeat (15) tick();
      check("t5_no_early_done", req_done, 0);
      check("t5_no_early_err", error, 0);
      check("t5_busy", busy, 1);
      tick();
      check("t5_wd_done", req_done, 2'b01);
      check("t5_wd_err", error, 1);
      tick();
      check("t5_idle", busy, 0);
      check("t5_next_ready", req_ready, 2'b10);
      tick();
      check("t5_next_gid", grant_id, 1);
      check("t5_next_start", obi_start, 1);
      check("t5_next_addr", obi_initial_addr, 32'h7000);
      req_valid = 2'b00;
      tick();
      obi_done = 1'b1;
      tick();
      obi_done = 1'b0;
      check("t5_next_done", req_done, 2'b10);
      tick();
`else
      // Without the watchdog a stalled engine keeps the job owned
      reset_dut();
      set_req(0, 32'h6000, 16'd7);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      repeat (20) tick();
      check("t5_still_busy", busy, 1);
      check("t5_no_done", req_done, 0);
      check("t5_no_err", error, 0);
      obi_done = 1'b1;
      tick();
      obi_done = 1'b0;
      check("t5_done", req_done, 2'b01);
      tick();
`endif

      // Reset in the middle of a job, then round-robin restarts at requester 0
      reset_dut();
      set_req(0, 32'h8000, 16'd0);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      set_req(1, 32'h9000, 16'd5);
      req_valid = 2'b10;
      #1 check("t6_ready1", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      check("t6_rst_busy", busy, 0);
      check("t6_rst_start", obi_start, 0);
      check("t6_rst_done", req_done, 0);
      check("t6_rst_err", error, 0);
      check("t6_rst_gid", grant_id, 0);
      check("t6_rst_addr", obi_initial_addr, 0);
      check("t6_rst_limit", obi_limit_in, 0);
      check("t6_rst_ready", req_ready, 0);
      rst = 1'b0;
      set_req(0, 32'hA000, 16'd1);
      req_valid = 2'b11;
      #1 check("t6_ready0", req_ready, 2'b01);
      tick();
      check("t6_gid", grant_id, 0);
      check("t6_addr", obi_initial_addr, 32'hA000);
      check("t6_no_stale_done", done_cnt - d0, 0);
      req_valid = 2'b00;
      tick();
      obi_done = 1'b1;
      tick();
      obi_done = 1'b0;
      check("t6_done", req_done, 2'b01);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
